// File: rtl/obuf_arb_pkg.sv
// obuf_arb shared constants: direction indices, payload width, FIFO depth.
// Also provides the modulo-5 wrap helper used by the round-robin search.
package obuf_arb_pkg;

  localparam int PKT_W      = 32;
  localparam int OBUF_DEPTH = 2;
  localparam int N_REQ      = 5;

  localparam logic [2:0] DIR_N = 3'd0;
  localparam logic [2:0] DIR_S = 3'd1;
  localparam logic [2:0] DIR_E = 3'd2;
  localparam logic [2:0] DIR_W = 3'd3;
  localparam logic [2:0] DIR_B = 3'd4;

  // Reset pointer so that DIR_N is searched first.
  localparam logic [2:0] LAST_RST = DIR_B;

  function automatic logic [2:0] wrap5(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction

endpackage

// File: rtl/obuf_arb_rr_arb5.sv
// rr_arb5: combinational 5-input round-robin arbiter.
// Ports: req, last (previous winner), en -> one-hot gnt, gnt_idx.
module rr_arb5
  import obuf_arb_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] last,
  input  logic       en,
  output logic [4:0] gnt,
  output logic [2:0] gnt_idx
);

  logic [2:0] idx;
  logic       found;

  // Walk last+1 .. last+5 (mod 5); first asserted request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = last;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= 5; k++) begin
      idx = wrap5({1'b0, last} + 4'(k));
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/obuf_arb.sv
// obuf_arb: per-direction output stage; round-robin over 5 input buffers,
// winner payload into a DEPTH-entry FIFO, FIFO head drives the link.
// Ports: clk, rst_n (async low), arb_req, payload_i, arb_gnt, obuf_rdy,
// out_vld, out_rdy, out_payload; perf_stall_cnt with OBUF_PERF_EN.
module obuf_arb
  import obuf_arb_pkg::*;
#(
  parameter int PYLD_W = PKT_W,
  parameter int DEPTH  = OBUF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4:0]              arb_req,
  input  logic [N_REQ*PYLD_W-1:0] payload_i,
  output logic [4:0]              arb_gnt,
  output logic                    obuf_rdy,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [PYLD_W-1:0]       out_payload
`ifdef OBUF_PERF_EN
  ,
  output logic [15:0]             perf_stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [2:0]        last_q, last_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PYLD_W-1:0] mem_q [DEPTH];
  logic [PYLD_W-1:0] mem_d [DEPTH];

  logic [2:0] gnt_idx;
  logic       push;
  logic       pop;

  // Registered-only ready: full-with-pop still refuses the push.
  assign obuf_rdy    = (count_q != FULL);
  assign out_vld     = (count_q != '0);
  assign out_payload = mem_q[rd_ptr_q];

  rr_arb5 u_arb (
    .req     (arb_req),
    .last    (last_q),
    .en      (obuf_rdy),
    .gnt     (arb_gnt),
    .gnt_idx (gnt_idx)
  );

  assign push = |arb_gnt;
  assign pop  = out_vld & out_rdy;

  always_comb begin
    last_d   = last_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = payload_i[int'(gnt_idx)*PYLD_W +: PYLD_W];
      wr_ptr_d        = wr_ptr_q + AW'(1);
      last_d          = gnt_idx;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= LAST_RST;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      last_q   <= last_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

`ifdef OBUF_PERF_EN
  logic [15:0] perf_q, perf_d;

  // Saturating count of cycles the link is offered but not taken.
  always_comb begin
    perf_d = perf_q;
    if (out_vld && !out_rdy && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_obuf_arb.sv
// tb_obuf_arb: directed bench for obuf_arb with a queue/modulo model.
// Define OBUF_PERF_EN to also cover the stall counter.
module tb_obuf_arb;
  import obuf_arb_pkg::*;

  localparam int W = 32;
  localparam int D = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [4:0]     arb_req = '0;
  logic [5*W-1:0] payload_i;
  logic [4:0]     arb_gnt;
  logic           obuf_rdy;
  logic           out_vld;
  logic           out_rdy = 1'b0;
  logic [W-1:0]   out_payload;
`ifdef OBUF_PERF_EN
  logic [15:0]    perf_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] mq[$];
  int           m_last = 4;
  int           m_perf = 0;

  logic [4:0]   g_last;
  logic [W-1:0] p_last;
  logic         r_last;
  logic         v_last;

  obuf_arb #(.PYLD_W(W), .DEPTH(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .arb_req        (arb_req),
    .payload_i      (payload_i),
    .arb_gnt        (arb_gnt),
    .obuf_rdy       (obuf_rdy),
    .out_vld        (out_vld),
    .out_rdy        (out_rdy),
    .out_payload    (out_payload)
`ifdef OBUF_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pay(input int i);
    return 32'hC0DE_0100 + W'(i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] model_gnt(input logic [4:0] req);
    if (mq.size() >= D) return 5'b0;
    for (int k = 1; k <= 5; k++) begin
      int idx;
      idx = (m_last + k) % 5;
      if (req[idx]) return 5'(1 << idx);
    end
    return 5'b0;
  endfunction

  // One cycle: drive at negedge, compare at +1, update model at posedge.
  task automatic step(input logic [4:0] req, input logic rdy);
    logic [4:0] eg;
    arb_req = req;
    out_rdy = rdy;
    #1;
    eg = model_gnt(req);
    chk("gnt", 32'(arb_gnt), 32'(eg));
    chk("obuf_rdy", 32'(obuf_rdy), 32'(mq.size() < D));
    chk("out_vld", 32'(out_vld), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("out_payload", out_payload, mq[0]);
`ifdef OBUF_PERF_EN
    chk("perf", 32'(perf_stall_cnt), 32'(m_perf));
`endif
    g_last = arb_gnt;
    p_last = out_payload;
    r_last = obuf_rdy;
    v_last = out_vld;
    @(posedge clk);
    if (mq.size() != 0) begin
      if (rdy) void'(mq.pop_front());
      else if (m_perf < 65535) m_perf++;
    end
    for (int i = 0; i < 5; i++) begin
      if (eg[i]) begin
        mq.push_back(pay(i));
        m_last = i;
      end
    end
    @(negedge clk);
  endtask

  // Called at a negedge; asserts reset between edges.
  task automatic do_reset();
    arb_req = '0;
    rst_n   = 1'b0;
    #1;
    chk("rst_vld", 32'(out_vld), 32'd0);
    chk("rst_rdy", 32'(obuf_rdy), 32'd1);
    chk("rst_pay", out_payload, 32'd0);
    chk("rst_gnt", 32'(arb_gnt), 32'd0);
`ifdef OBUF_PERF_EN
    chk("rst_perf", 32'(perf_stall_cnt), 32'd0);
`endif
    mq.delete();
    m_last = 4;
    m_perf = 0;
    #3;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [4:0] vreq [12] = '{5'b10110, 5'b01011, 5'b11000, 5'b00111,
                            5'b00000, 5'b11111, 5'b11111, 5'b00001,
                            5'b10010, 5'b01100, 5'b00000, 5'b00000};
  logic       vrdy [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                            1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    for (int i = 0; i < 5; i++) payload_i[i*W +: W] = pay(i);
    @(negedge clk);
    do_reset();

    // Full request set: strict rotation 0..4,0 at one word per cycle.
    for (int k = 0; k < 6; k++) begin
      step(5'b11111, 1'b1);
      chk("rr_seq", 32'(g_last), 32'(1 << (k % 5)));
      if (k > 0) chk("link_seq", p_last, pay((k - 1) % 5));
    end
    step(5'b00000, 1'b1);
    chk("link_tail", p_last, pay(0));
    step(5'b00000, 1'b1);

    // Stalled link fills FIFO with 0 then 2, then backpressures.
    do_reset();
    step(5'b00101, 1'b0);
    chk("c_g0", 32'(g_last), 32'h01);
    step(5'b00101, 1'b0);
    chk("c_g2", 32'(g_last), 32'h04);
    chk("c_head", p_last, pay(0));
    step(5'b00101, 1'b0);
    chk("c_nogrant", 32'(g_last), 32'h00);
    chk("c_full", 32'(r_last), 32'd0);
    step(5'b00000, 1'b1);
    chk("c_pop0", p_last, pay(0));
    step(5'b00000, 1'b1);
    chk("c_pop2", p_last, pay(2));
    step(5'b00000, 1'b1);

    // Full with pop: no grant in the pop cycle, grant next cycle.
    do_reset();
    step(5'b00011, 1'b0);
    step(5'b00011, 1'b0);
    chk("d_g1", 32'(g_last), 32'h02);
    step(5'b01000, 1'b1);
    chk("d_nogrant", 32'(g_last), 32'h00);
    chk("d_rdy0", 32'(r_last), 32'd0);
    step(5'b01000, 1'b1);
    chk("d_g3", 32'(g_last), 32'h08);
    chk("d_rdy1", 32'(r_last), 32'd1);
    step(5'b00000, 1'b1);
    step(5'b00000, 1'b1);

    // Single requester streams through with count steady at 1.
    for (int k = 0; k < 5; k++) begin
      step(5'b10000, 1'b1);
      chk("e_g4", 32'(g_last), 32'h10);
      if (k > 0) begin
        chk("e_vld", 32'(v_last), 32'd1);
        chk("e_rdy", 32'(r_last), 32'd1);
        chk("e_pay", p_last, pay(4));
      end
    end
    step(5'b00000, 1'b1);

    // Mixed directed vectors checked against the model only.
    for (int i = 0; i < 12; i++) step(vreq[i], vrdy[i]);

`ifdef OBUF_PERF_EN
    do_reset();
    step(5'b00001, 1'b0);
    out_rdy = 1'b0;
    arb_req = '0;
    repeat (70000) begin
      @(posedge clk);
      if (m_perf < 65535) m_perf++;
    end
    @(negedge clk);
    #1;
    chk("perf_sat", 32'(perf_stall_cnt), 32'hFFFF);
    chk("perf_model", 32'(perf_stall_cnt), 32'(m_perf));
    chk("perf_vld", 32'(out_vld), 32'd1);
    @(negedge clk);
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
